ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch_pkg.sv | 18 +
 rtl/ifetch_q.sv | 82 ++++++++
 rtl/ifetch.sv | 133 +++++++++++++
 tb/tb_ifetch.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package ifetch_pkg;

    localparam int IFQ_DEPTH = 2;
    localparam logic [31:0] IFETCH_RESET_ADDR = 32'h0000_0000;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } ifetch_state_e;

    // Clears the byte offset; bit 0 follows JALR semantics, bit 1 is dropped after the misalignment check.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifetch_q.sv
// Two-entry {inst, pc} FIFO feeding decode; flush dominates push, pop is applied before flush.
module ifetch_q
    import ifetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [63:0] wdata,
    input  logic        pop,
    input  logic        flush,
    output logic [63:0] rdata,
    output logic [1:0]  count
);

    logic [63:0] mem_r [IFQ_DEPTH];
    logic        wr_ptr_r;
    logic        rd_ptr_r;
    logic [1:0]  count_r;
    logic        do_pop_s;
    logic        do_push_s;

    // Qualify push/pop against occupancy and flush.
    always_comb begin
        do_pop_s  = pop && (count_r != 2'd0);
        do_push_s = push && !flush && ((count_r != 2'd2) || do_pop_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r[0] <= 64'd0;
            mem_r[1] <= 64'd0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;

    ifetch_q_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .flush (flush),
        .count (count_r)
    );

endmodule

// The fetch credit rule keeps the queue from ever receiving a push while full.
module ifetch_q_chk (
    input logic       clk,
    input logic       rst_n,
    input logic       push,
    input logic       flush,
    input logic [1:0] count
);

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) !(push && !flush && (count == 2'd2))
    );

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: credit-limited requests to instruction memory, in-order response
// tracking with stale-drop after redirects, and a registered hand-off queue to decode.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = IFETCH_RESET_ADDR
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_inst_ready,
    output logic        o_misaligned
);

    ifetch_state_e state_r, state_n;
    logic [31:0]   fetch_pc_r, fetch_pc_n;
    logic [1:0]    out_r, out_n;
    logic [1:0]    stale_r, stale_n;
    logic          misaligned_r, misaligned_n;

    logic          req_s;
    logic          grant_s;
    logic          push_s;
    logic          pop_s;
    logic          inst_valid_s;
    logic [1:0]    q_count_s;
    logic [63:0]   q_head_s;
    logic [63:0]   q_wdata_s;
    logic [31:0]   resp_pc_s;

    // Request credit and response PC; non-stale responses are the contiguous run ending at fetch_pc-4.
    always_comb begin
        req_s        = (state_r == RUN) && (({1'b0, out_r} + {1'b0, q_count_s}) < 3'd2);
        grant_s      = req_s && i_imem_gnt;
        inst_valid_s = (q_count_s != 2'd0);
        pop_s        = inst_valid_s && i_inst_ready;
        resp_pc_s    = fetch_pc_r - {28'd0, out_r, 2'b00};
        q_wdata_s    = {i_imem_rdata, resp_pc_s};
    end

    // Next-state: control FSM, fetch PC, outstanding/stale accounting and queue push.
    always_comb begin
        state_n      = state_r;
        fetch_pc_n   = fetch_pc_r;
        stale_n      = stale_r;
        push_s       = 1'b0;
        out_n        = out_r + {1'b0, grant_s} - {1'b0, i_imem_rvalid};
        misaligned_n = i_redirect && i_redirect_pc[1] && (state_r != RESET);

        case (state_r)
            RESET: state_n = RUN;
            RUN: begin
                if (i_redirect && i_redirect_pc[1]) begin
                    state_n = HALT;
                end else begin
                    state_n = RUN;
                end
            end
            HALT: begin
                if (i_redirect && !i_redirect_pc[1]) begin
                    state_n = RUN;
                end else begin
                    state_n = HALT;
                end
            end
            default: state_n = RESET;
        endcase

        if (i_redirect) begin
            // Everything still on the bus after this edge, including a same-cycle grant, is stale.
            fetch_pc_n = word_align(i_redirect_pc);
            stale_n    = out_n;
        end else begin
            if (grant_s) begin
                fetch_pc_n = fetch_pc_r + 32'd4;
            end else begin
                fetch_pc_n = fetch_pc_r;
            end
            if (i_imem_rvalid && (stale_r != 2'd0)) begin
                stale_n = stale_r - 2'd1;
            end else if (i_imem_rvalid) begin
                push_s = 1'b1;
            end else begin
                stale_n = stale_r;
            end
        end
    end

    // State registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= RESET;
            fetch_pc_r   <= word_align(RESET_ADDR);
            out_r        <= 2'd0;
            stale_r      <= 2'd0;
            misaligned_r <= 1'b0;
        end else begin
            state_r      <= state_n;
            fetch_pc_r   <= fetch_pc_n;
            out_r        <= out_n;
            stale_r      <= stale_n;
            misaligned_r <= misaligned_n;
        end
    end

    ifetch_q u_ifq (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (push_s),
        .wdata (q_wdata_s),
        .pop   (pop_s),
        .flush (i_redirect),
        .rdata (q_head_s),
        .count (q_count_s)
    );

    assign o_imem_req   = req_s;
    assign o_imem_addr  = word_align(fetch_pc_r);
    assign o_inst_valid = inst_valid_s;
    assign o_inst       = q_head_s[63:32];
    assign o_inst_pc    = q_head_s[31:0];
    assign o_misaligned = misaligned_r;

endmodule

// File: tb/tb_ifetch.sv
// Randomized bench for ifetch against a transaction-level model of the fetch stream.
module tb_ifetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        i_inst_ready;
    logic        o_misaligned;

    always #5 i_clk = ~i_clk;

    ifetch #(.RESET_ADDR(RST_PC)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_inst_valid  (o_inst_valid),
        .o_inst        (o_inst),
        .o_inst_pc     (o_inst_pc),
        .i_inst_ready  (i_inst_ready),
        .o_misaligned  (o_misaligned)
    );

    // One bus transaction: address seen by memory, PC the model expects, fetch epoch, due cycle.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int          epoch;
        int          due;
    } txn_t;

    txn_t        mem_q[$];
    logic [31:0] dq[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          last_due = 0;
    logic [31:0] mdl_pc = 32'd0;
    bit          in_reset = 1'b0;
    bit          halted = 1'b0;
    bit          exp_mis = 1'b0;

    bit          k_gnt = 1'b0;
    bit          k_ready = 1'b0;
    bit          k_redir = 1'b0;
    logic [31:0] k_rpc = 32'd0;
    int          k_lat = 0;

    int          grants = 0;
    int          first_grant = -1;
    logic [31:0] first_grant_addr = 32'd0;
    int          first_valid = -1;
    logic [31:0] first_valid_pc = 32'd0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a ^ 32'h1357_9BDF) + 32'h0000_0011;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive at negedge, check at negedge+1, advance the model at posedge.
    task automatic step();
        txn_t        t;
        bit          rv;
        bit          s_req;
        bit          s_valid;
        bit          grant;
        logic [31:0] s_addr;
        logic [31:0] s_pc;
        rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        i_imem_gnt    = k_gnt;
        i_inst_ready  = k_ready;
        i_imem_rvalid = rv;
        i_imem_rdata  = rv ? inst_of(mem_q[0].addr) : $urandom();
        i_redirect    = k_redir;
        i_redirect_pc = k_redir ? k_rpc : $urandom();
        #1;
        s_req   = o_imem_req;
        s_addr  = o_imem_addr;
        s_valid = o_inst_valid;
        s_pc    = o_inst_pc;
        check("inst_valid", 32'(o_inst_valid), 32'(dq.size() != 0));
        if (dq.size() != 0) begin
            check("inst_pc", o_inst_pc, dq[0]);
            check("inst", o_inst, inst_of(dq[0]));
        end
        check("imem_req", 32'(o_imem_req),
              32'(!in_reset && !halted && ((mem_q.size() + dq.size()) < 2)));
        if (o_imem_req) begin
            check("imem_addr", o_imem_addr, mdl_pc);
        end
        check("misaligned", 32'(o_misaligned), 32'(exp_mis));
        grant = s_req && k_gnt;
        @(posedge i_clk);
        if (s_valid && first_valid < 0) begin
            first_valid    = cyc;
            first_valid_pc = s_pc;
        end
        if (s_valid && k_ready && dq.size() != 0) begin
            void'(dq.pop_front());
        end
        if (rv) begin
            t = mem_q.pop_front();
            if (!k_redir && t.epoch == epoch) begin
                dq.push_back(t.pc);
            end
        end
        if (grant) begin
            t.addr  = s_addr;
            t.pc    = mdl_pc;
            t.epoch = epoch;
            t.due   = cyc + 1 + int'($urandom_range(0, k_lat));
            if (t.due < last_due) begin
                t.due = last_due;
            end
            last_due = t.due;
            mem_q.push_back(t);
            grants++;
            if (first_grant < 0) begin
                first_grant      = cyc;
                first_grant_addr = s_addr;
            end
        end
        exp_mis = 1'b0;
        if (k_redir) begin
            epoch++;
            dq.delete();
            exp_mis = k_rpc[1];
            halted  = k_rpc[1];
            mdl_pc  = k_rpc & 32'hFFFF_FFFC;
        end else if (grant) begin
            mdl_pc = mdl_pc + 32'd4;
        end
        in_reset = 1'b0;
        cyc++;
        @(negedge i_clk);
    endtask

    // Asserts reset mid-cycle, checks outputs immediately, releases on the next negedge.
    task automatic apply_reset();
        #2;
        i_rst_n       = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_gnt    = 1'b0;
        i_redirect    = 1'b0;
        #1;
        check("rst_req", 32'(o_imem_req), 32'd0);
        check("rst_valid", 32'(o_inst_valid), 32'd0);
        check("rst_mis", 32'(o_misaligned), 32'd0);
        check("rst_inst", o_inst, 32'd0);
        check("rst_inst_pc", o_inst_pc, 32'd0);
        mem_q.delete();
        dq.delete();
        epoch++;
        last_due    = 0;
        halted      = 1'b0;
        exp_mis     = 1'b0;
        mdl_pc      = RST_PC;
        in_reset    = 1'b1;
        first_grant = -1;
        first_valid = -1;
        @(posedge i_clk);
        @(negedge i_clk);
        cyc++;
        i_rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] held_pc;
        logic [31:0] r;
        int          g;
        bit          hit;
        i_rst_n       = 1'b0;
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = 32'd0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'd0;
        i_inst_ready  = 1'b0;
        @(negedge i_clk);

        // Reset release, streaming at full rate with 1-cycle memory latency.
        k_gnt = 1'b1; k_ready = 1'b1; k_lat = 0;
        apply_reset();
        repeat (12) step();
        check("a_first_addr", first_grant_addr, RST_PC);
        check("a_valid_lat", 32'(first_valid - first_grant), 32'd2);
        check("a_first_pc", first_valid_pc, RST_PC);

        // Backpressure.
        k_ready = 1'b0;
        g = grants;
        repeat (4) step();
        held_pc = o_inst_pc;
        repeat (6) step();
        check("b_grants_le2", 32'((grants - g) <= 2), 32'd1);
        check("b_hold_valid", 32'(o_inst_valid), 32'd1);
        check("b_hold_pc", o_inst_pc, held_pc);
        k_ready = 1'b1;
        repeat (8) step();

        // Redirect with two outstanding.
        k_lat = 4;
        for (int i = 0; i < 40 && mem_q.size() < 2; i++) step();
        check("c_two_out", 32'(mem_q.size()), 32'd2);
        k_redir = 1'b1; k_rpc = 32'h0000_0200;
        step();
        k_redir = 1'b0;
        first_valid = -1;
        for (int i = 0; i < 60 && first_valid < 0; i++) step();
        check("c_first_pc", first_valid_pc, 32'h0000_0200);

        // Redirect coinciding with rvalid and grant.
        k_lat = 0;
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (o_imem_req && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        check("d_coincide", 32'(hit), 32'd1);
        k_redir = 1'b1; k_rpc = 32'h0000_0280;
        step();
        k_redir = 1'b0;
        first_grant = -1;
        first_valid = -1;
        for (int i = 0; i < 40 && first_valid < 0; i++) step();
        check("d_next_addr", first_grant_addr, 32'h0000_0280);
        check("d_first_pc", first_valid_pc, 32'h0000_0280);

        // Misaligned redirect halts fetch; aligned redirect resumes it.
        k_redir = 1'b1; k_rpc = 32'h0000_0302;
        step();
        k_redir = 1'b0;
        check("e_mis_pulse", 32'(o_misaligned), 32'd1);
        g = grants;
        repeat (8) step();
        check("e_no_req", 32'(grants - g), 32'd0);
        k_redir = 1'b1; k_rpc = 32'h0000_0400;
        step();
        k_redir = 1'b0;
        first_grant = -1;
        repeat (6) step();
        check("e_resume_addr", first_grant_addr, 32'h0000_0400);

        // Randomized traffic, redirects and misaligned targets.
        for (int i = 0; i < 1500; i++) begin
            k_gnt   = ($urandom_range(0, 3) != 0);
            k_ready = ($urandom_range(0, 3) != 0);
            k_lat   = int'($urandom_range(0, 3));
            k_redir = !in_reset && ($urandom_range(0, halted ? 3 : 15) == 0);
            r = $urandom();
            case ($urandom_range(0, 7))
                0, 1, 2, 3, 4: r[1] = 1'b0;
                5:             r = 32'hFFFF_FFF8 | (r & 32'h0000_0001);
                default:       r = r;
            endcase
            k_rpc = r;
            step();
        end
        k_redir = 1'b0;

        // Reset with two outstanding.
        k_gnt = 1'b1; k_ready = 1'b1;
        k_redir = 1'b1; k_rpc = 32'h0000_0500;
        step();
        k_redir = 1'b0;
        k_lat = 5;
        for (int i = 0; i < 40 && mem_q.size() < 2; i++) step();
        check("g_two_out", 32'(mem_q.size()), 32'd2);
        apply_reset();
        k_lat = 0;
        repeat (6) step();
        check("g_restart", first_grant_addr, RST_PC);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
